apb_wait_slave: RTL

//  APB completer: byte-wide register file with programmable wait-state insertion, a read-only

---
 rtl/apb_wait_slave_pkg.sv | 15 +
 rtl/apb_wait_slave_if.sv | 24 ++
 rtl/apb_wait_slave_counter.sv | 31 +++
 rtl/apb_wait_slave.sv | 83 ++++++++
 4 files changed

// File: rtl/apb_wait_slave_pkg.sv
// Shared types and helpers for the APB wait-state completer.
package apb_wait_slave_pkg;

  // Two-state transfer FSM: waiting for a setup phase, or inside the access phase.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_t;

  // Wait counter width; at least one bit so WAIT_STATES=0 still has a legal vector.
  function automatic int cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/apb_wait_slave_if.sv
// APB completer-side bus bundle (select, phase, address/data and response).
interface apb_wait_slave_if #(
  parameter int ADDRESS_SIZE = 5,
  parameter int DATA_SIZE    = 8
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDRESS_SIZE-1:0] paddr;
  logic [DATA_SIZE-1:0]    pwdata;
  logic                    pready;
  logic [DATA_SIZE-1:0]    prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_wait_slave_counter.sv
// Wait-state down-counter: loads WAIT_STATES on setup, decrements while stalled,
// flags zero when the access phase may complete. Saturates at zero.
module apb_wait_slave_counter
  import apb_wait_slave_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = cnt_width(WAIT_STATES);

  logic [CW-1:0] cnt;

  // Load has priority over decrement; decrement never wraps below zero.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WAIT_STATES);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer: byte register file with programmable wait states, a read-only
// upper window (writes there complete with pslverr and are dropped) and abort handling.
module apb_wait_slave
  import apb_wait_slave_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int ADDRESS_SIZE = 5,
  parameter int WAIT_STATES  = 2,
  parameter int RO_BASE      = 'h18
) (
  input  logic             clock,
  input  logic             resetn,
  apb_wait_slave_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE-1:0] RO_ADDR = ADDRESS_SIZE'(RO_BASE);

  apb_state_t              state;
  logic [ADDRESS_SIZE-1:0] a_q;
  logic                    w_q;
  logic [DATA_SIZE-1:0]    d_q;
  logic [DATA_SIZE-1:0]    prdata_q;
  logic [DATA_SIZE-1:0]    mem [DEPTH];

  logic is_setup;
  logic in_access;
  logic zero;
  logic ro_hit;

  // A setup phase is accepted from either state; in ACCESS it is a protocol
  // error that simply restarts the transfer with the new request.
  assign is_setup  = bus.psel & ~bus.penable;
  assign in_access = (state == ST_ACCESS) & bus.psel & bus.penable;
  assign ro_hit    = (a_q >= RO_ADDR);

  assign bus.pready  = in_access & zero;
  assign bus.pslverr = bus.pready & w_q & ro_hit;
  assign bus.prdata  = prdata_q;

  apb_wait_slave_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_counter (
    .clock  (clock),
    .resetn (resetn),
    .load   (is_setup),
    .dec    (in_access & ~zero),
    .zero   (zero)
  );

  // Transfer FSM, request latches, read-data register and register file.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      w_q      <= 1'b0;
      d_q      <= '0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i >= RO_BASE) ? DATA_SIZE'(i) : '0;
      end
    end else if (is_setup) begin
      a_q      <= bus.paddr;
      w_q      <= bus.pwrite;
      d_q      <= bus.pwdata;
      prdata_q <= bus.pwrite ? '0 : mem[bus.paddr];
      state    <= ST_ACCESS;
    end else if (state == ST_ACCESS) begin
      if (!bus.psel) begin
        // Master abandoned the transfer: nothing is written.
        prdata_q <= '0;
        state    <= ST_IDLE;
      end else if (zero) begin
        // Completion edge (psel & penable & count exhausted).
        if (w_q && !ro_hit) begin
          mem[a_q] <= d_q;
        end
        prdata_q <= '0;
        state    <= ST_IDLE;
      end
    end
  end

endmodule
